// File: rtl/dot_product_seq.sv
// Sequencer that streams pixel/weight memory words into DotProductSt one beat per cycle,
// waits out the datapath latency and returns one result per neuron on a valid/ready port.
module dot_product_seq #(
  parameter int PIXEL_N     = 10,
  parameter int PARALLEL    = 1,
  parameter int NEURON_N    = 3,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int VAL_SIZE    = 26,
  parameter int DP_LATENCY  = 8,
  localparam int BEATS = PIXEL_N / PARALLEL,
  localparam int PAW   = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int WAW   = (NEURON_N * BEATS > 1) ? $clog2(NEURON_N * BEATS) : 1,
  localparam int IW    = (NEURON_N > 1) ? $clog2(NEURON_N) : 1
) (
  input  logic                            clk,
  input  logic                            GlobalReset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [PAW-1:0]                  pix_addr,
  input  logic [PARALLEL*PIXEL_SIZE-1:0]  pix_rd_data,
  output logic [WAW-1:0]                  wgt_addr,
  input  logic [PARALLEL*WEIGHT_SIZE-1:0] wgt_rd_data,
  output logic [PARALLEL*PIXEL_SIZE-1:0]  dp_pixels,
  output logic [PARALLEL*WEIGHT_SIZE-1:0] dp_weights,
  output logic                            dp_first,
  output logic                            dp_last,
  input  logic [VAL_SIZE-1:0]             dp_value,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [VAL_SIZE-1:0]             res_data,
  output logic [IW-1:0]                   res_idx
);

  localparam int DW = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
  localparam logic [PAW-1:0] LAST_B = PAW'(BEATS - 1);
  localparam logic [IW-1:0]  LAST_N = IW'(NEURON_N - 1);

  // IDLE: wait for start | STREAM: issue addresses | DRAIN: wait out latency | OUTPUT: hold result
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_OUTPUT} state_t;

  state_t                            r_state;
  logic [PAW-1:0]                    r_b;
  logic [WAW-1:0]                    r_wa;
  logic [IW-1:0]                     r_n;
  logic                              r_v1, r_v2, r_f1, r_f2, r_l1, r_l2;
  logic [DW-1:0]                     r_cnt;
  logic                              r_arm;
  logic                              r_busy, r_done, r_res_valid;
  logic [VAL_SIZE-1:0]               r_res_data;
  logic [IW-1:0]                     r_res_idx;
  logic [PARALLEL*PIXEL_SIZE-1:0]    r_dp_pix;
  logic [PARALLEL*WEIGHT_SIZE-1:0]   r_dp_wgt;
  logic                              r_dp_first, r_dp_last;

  logic [PAW-1:0] w_b_next;
  logic           w_last_beat;
  logic           w_last_n;

  assign w_b_next    = r_b + PAW'(1);
  assign w_last_beat = (r_b == LAST_B);
  assign w_last_n    = (r_n == LAST_N);

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state     <= S_IDLE;
      r_b         <= '0;
      r_wa        <= '0;
      r_n         <= '0;
      r_v1        <= 1'b0;
      r_f1        <= 1'b0;
      r_l1        <= 1'b0;
      r_cnt       <= '0;
      r_arm       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_STREAM;
            r_busy  <= 1'b1;
            r_n     <= '0;
            r_b     <= '0;
            r_wa    <= '0;
            r_v1    <= 1'b1;
            r_f1    <= 1'b1;
            r_l1    <= 1'(BEATS == 1);
          end
        end
        S_STREAM: begin
          r_f1 <= 1'b0;
          if (w_last_beat) begin
            r_state <= S_DRAIN;
            r_v1    <= 1'b0;
            r_l1    <= 1'b0;
          end else begin
            r_b  <= w_b_next;
            r_wa <= r_wa + WAW'(1);
            r_l1 <= (w_b_next == LAST_B);
          end
        end
        S_DRAIN: begin
          // The latency count is referenced to the last beat actually reaching the datapath.
          if (r_dp_last) begin
            r_cnt <= DW'(DP_LATENCY - 1);
            r_arm <= 1'b1;
          end else if (r_arm) begin
            if (r_cnt == '0) begin
              r_arm       <= 1'b0;
              r_res_data  <= dp_value;
              r_res_idx   <= r_n;
              r_res_valid <= 1'b1;
              r_state     <= S_OUTPUT;
            end else begin
              r_cnt <= r_cnt - DW'(1);
            end
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_last_n) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_STREAM;
              r_n     <= r_n + IW'(1);
              r_b     <= '0;
              r_wa    <= r_wa + WAW'(1);
              r_v1    <= 1'b1;
              r_f1    <= 1'b1;
              r_l1    <= 1'(BEATS == 1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory read latency is one cycle, so beat markers lag the address by two stages.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_v2       <= 1'b0;
      r_f2       <= 1'b0;
      r_l2       <= 1'b0;
      r_dp_pix   <= '0;
      r_dp_wgt   <= '0;
      r_dp_first <= 1'b0;
      r_dp_last  <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      r_f2 <= r_f1;
      r_l2 <= r_l1;
      if (r_v2) begin
        r_dp_pix   <= pix_rd_data;
        r_dp_wgt   <= wgt_rd_data;
        r_dp_first <= r_f2;
        r_dp_last  <= r_l2;
      end else begin
        r_dp_pix   <= '0;
        r_dp_wgt   <= '0;
        r_dp_first <= 1'b0;
        r_dp_last  <= 1'b0;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pix_addr   = r_b;
  assign wgt_addr   = r_wa;
  assign dp_pixels  = r_dp_pix;
  assign dp_weights = r_dp_wgt;
  assign dp_first   = r_dp_first;
  assign dp_last    = r_dp_last;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_idx    = r_res_idx;

endmodule

// File: tb/tb_dot_product_seq.sv
// Bench for dot_product_seq: behavioural memories and datapath around a scalar and a
// two-lane instance, results compared against plain dot-product sums and cycle formulas.
module tb_dot_product_seq;
  localparam int DPL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2, res_ready;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  // scalar instance
  logic        busy, done, dp_first, dp_last, res_valid;
  logic [3:0]  pix_addr;
  logic [4:0]  wgt_addr;
  logic [9:0]  pix_rd, dp_pix;
  logic [18:0] wgt_rd, dp_wgt;
  logic [25:0] dp_value, res_data;
  logic [1:0]  res_idx;

  // two-lane instance
  logic        busy2, done2, dp_first2, dp_last2, res_valid2;
  logic [2:0]  pix_addr2;
  logic [3:0]  wgt_addr2;
  logic [19:0] pix_rd2, dp_pix2;
  logic [37:0] wgt_rd2, dp_wgt2;
  logic [25:0] dp_value2, res_data2;
  logic [1:0]  res_idx2;

  dot_product_seq u_dut (
    .clk(clk), .GlobalReset(rst), .start(start), .busy(busy), .done(done),
    .pix_addr(pix_addr), .pix_rd_data(pix_rd), .wgt_addr(wgt_addr), .wgt_rd_data(wgt_rd),
    .dp_pixels(dp_pix), .dp_weights(dp_wgt), .dp_first(dp_first), .dp_last(dp_last),
    .dp_value(dp_value), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx)
  );

  dot_product_seq #(.PARALLEL(2)) u_dut2 (
    .clk(clk), .GlobalReset(rst), .start(start2), .busy(busy2), .done(done2),
    .pix_addr(pix_addr2), .pix_rd_data(pix_rd2), .wgt_addr(wgt_addr2), .wgt_rd_data(wgt_rd2),
    .dp_pixels(dp_pix2), .dp_weights(dp_wgt2), .dp_first(dp_first2), .dp_last(dp_last2),
    .dp_value(dp_value2), .res_valid(res_valid2), .res_ready(res_ready),
    .res_data(res_data2), .res_idx(res_idx2)
  );

  // reference data and memories
  int unsigned px [10];
  int unsigned wt [3][10];
  logic [9:0]  pmem  [10];
  logic [18:0] wmem  [30];
  logic [19:0] pmem2 [5];
  logic [37:0] wmem2 [15];

  always @(posedge clk) begin
    pix_rd  <= pmem[pix_addr];
    wgt_rd  <= wmem[wgt_addr];
    pix_rd2 <= pmem2[pix_addr2];
    wgt_rd2 <= wmem2[wgt_addr2];
  end

  // datapath models: accumulate from first to last, result appears DPL cycles after last
  logic [25:0] acc1, acc2;
  logic [25:0] pipe1 [DPL];
  logic [25:0] pipe2 [DPL];
  wire  [25:0] sum1 = 26'(dp_pix) * 26'(dp_wgt);
  wire  [25:0] sum2 = 26'(dp_pix2[9:0]) * 26'(dp_wgt2[18:0]) + 26'(dp_pix2[19:10]) * 26'(dp_wgt2[37:19]);
  wire  [25:0] tot1 = dp_first ? sum1 : acc1 + sum1;
  wire  [25:0] tot2 = dp_first2 ? sum2 : acc2 + sum2;
  always @(posedge clk) begin
    acc1 <= tot1;
    acc2 <= tot2;
    pipe1[0] <= dp_last ? tot1 : '0;
    pipe2[0] <= dp_last2 ? tot2 : '0;
    for (int i = 1; i < DPL; i++) begin
      pipe1[i] <= pipe1[i-1];
      pipe2[i] <= pipe2[i-1];
    end
  end
  assign dp_value  = pipe1[DPL-1];
  assign dp_value2 = pipe2[DPL-1];

  // event recorders
  int q_rv[$], q_hs_cyc[$], q_hs_data[$], q_hs_idx[$], q_first[$], q_last[$], q_done[$], q_bfall[$];
  int q2_rv[$], q2_hs_data[$], q2_hs_idx[$], q2_done[$];
  int n_beats = 0;
  int n_unstable = 0;
  logic prev_rv = 1'b0, prev_rdy = 1'b0, prev_busy = 1'b0, prev_rv2 = 1'b0;
  logic [25:0] prev_data = '0;

  always @(negedge clk) begin
    if (res_valid && !prev_rv) q_rv.push_back(cyc);
    if (res_valid && res_ready) begin
      q_hs_cyc.push_back(cyc);
      q_hs_data.push_back(int'(res_data));
      q_hs_idx.push_back(int'(res_idx));
    end
    if (prev_rv && !prev_rdy && !rst && (!res_valid || res_data !== prev_data)) n_unstable++;
    if (dp_first) q_first.push_back(cyc);
    if (dp_last) q_last.push_back(cyc);
    if (done) q_done.push_back(cyc);
    if (prev_busy && !busy) q_bfall.push_back(cyc);
    if (dp_wgt != '0) n_beats++;
    prev_rv = res_valid; prev_rdy = res_ready; prev_data = res_data; prev_busy = busy;
    if (res_valid2 && !prev_rv2) q2_rv.push_back(cyc);
    if (res_valid2 && res_ready) begin
      q2_hs_data.push_back(int'(res_data2));
      q2_hs_idx.push_back(int'(res_idx2));
    end
    if (done2) q2_done.push_back(cyc);
    prev_rv2 = res_valid2;
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int ref_sum(input int n);
    int s = 0;
    for (int i = 0; i < 10; i++) s += int'(px[i] * wt[n][i]);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    q_rv.delete(); q_hs_cyc.delete(); q_hs_data.delete(); q_hs_idx.delete();
    q_first.delete(); q_last.delete(); q_done.delete(); q_bfall.delete();
    q2_rv.delete(); q2_hs_data.delete(); q2_hs_idx.delete(); q2_done.delete();
    n_beats = 0;
    n_unstable = 0;
  endtask

  task automatic load_mem(input bit rnd);
    for (int i = 0; i < 10; i++) begin
      px[i] = rnd ? $urandom_range(0, 1023) : i;
      pmem[i] = 10'(px[i]);
      pmem2[i/2][(i%2)*10 +: 10] = 10'(px[i]);
      for (int n = 0; n < 3; n++) begin
        wt[n][i] = rnd ? $urandom_range(1, 1023) : n + 1;
        wmem[n*10+i] = 19'(wt[n][i]);
        wmem2[n*5+i/2][(i%2)*19 +: 19] = 19'(wt[n][i]);
      end
    end
  endtask

  task automatic do_start(output int t);
    t = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    int k = 0;
    while (q_done.size() == 0 && k < budget) begin step(); k++; end
    to = (q_done.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; res_ready = 1'b1;
    repeat (3) step();
    n_checks++; if ({busy, done, res_valid, dp_first, dp_last, dp_pix, dp_wgt, res_data, res_idx, pix_addr, wgt_addr} !== '0)
      $display("FAIL reset_outputs: got %0h want 0", {busy, done, res_valid, dp_first, dp_last, dp_pix, dp_wgt, res_data, res_idx, pix_addr, wgt_addr}); else n_pass++;
    n_checks++; if ({busy2, done2, res_valid2, dp_first2, dp_last2, dp_pix2, dp_wgt2, res_data2, res_idx2, pix_addr2, wgt_addr2} !== '0)
      $display("FAIL reset_outputs2: got %0h want 0", {busy2, done2, res_valid2, dp_first2, dp_last2, dp_pix2, dp_wgt2, res_data2, res_idx2, pix_addr2, wgt_addr2}); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int t; bit to;
    load_mem(0); clear_mon(); res_ready = 1'b1;
    do_start(t);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %0b want 1", busy); else n_pass++;
    wait_done(100, to);
    n_checks++; if (to !== 1'b0) $display("FAIL basic_timeout: got %0b want 0", to); else n_pass++;
    n_checks++; if (qget(q_first, 0) !== t + 3) $display("FAIL basic_first: got %0d want %0d", qget(q_first, 0), t + 3); else n_pass++;
    n_checks++; if (qget(q_last, 0) !== t + 12) $display("FAIL basic_last: got %0d want %0d", qget(q_last, 0), t + 12); else n_pass++;
    n_checks++; if (qget(q_rv, 0) !== t + 21) $display("FAIL basic_valid_time: got %0d want %0d", qget(q_rv, 0), t + 21); else n_pass++;
    n_checks++; if (qget(q_hs_idx, 0) !== 0) $display("FAIL basic_idx: got %0d want 0", qget(q_hs_idx, 0)); else n_pass++;
    n_checks++; if (qget(q_hs_data, 0) !== 45) $display("FAIL basic_data: got %0d want 45", qget(q_hs_data, 0)); else n_pass++;
  endtask

  task automatic test_full_run();
    int t; bit to;
    load_mem(0); clear_mon(); res_ready = 1'b1;
    do_start(t);
    wait_done(100, to);
    n_checks++; if (to !== 1'b0) $display("FAIL full_timeout: got %0b want 0", to); else n_pass++;
    for (int n = 0; n < 3; n++) begin
      n_checks++; if (qget(q_hs_cyc, n) !== t + 21 + 21*n) $display("FAIL full_hs_time%0d: got %0d want %0d", n, qget(q_hs_cyc, n), t + 21 + 21*n); else n_pass++;
      n_checks++; if (qget(q_hs_data, n) !== 45*(n+1)) $display("FAIL full_data%0d: got %0d want %0d", n, qget(q_hs_data, n), 45*(n+1)); else n_pass++;
      n_checks++; if (qget(q_hs_idx, n) !== n) $display("FAIL full_idx%0d: got %0d want %0d", n, qget(q_hs_idx, n), n); else n_pass++;
    end
    n_checks++; if (qget(q_done, 0) !== t + 64) $display("FAIL full_done_time: got %0d want %0d", qget(q_done, 0), t + 64); else n_pass++;
    n_checks++; if (qget(q_bfall, 0) !== t + 64) $display("FAIL full_busy_fall: got %0d want %0d", qget(q_bfall, 0), t + 64); else n_pass++;
    n_checks++; if (n_beats !== 30) $display("FAIL full_beats: got %0d want 30", n_beats); else n_pass++;
  endtask

  task automatic test_backpressure();
    int t; bit to;
    load_mem(1); clear_mon(); res_ready = 1'b0;
    do_start(t);
    while (cyc < t + 26) step();
    n_checks++; if (res_valid !== 1'b1) $display("FAIL bp_valid_held: got %0b want 1", res_valid); else n_pass++;
    res_ready = 1'b1;
    step();
    n_checks++; if ({pix_addr, wgt_addr} !== {4'd0, 5'd10}) $display("FAIL bp_n1_addr: got pix %0d wgt %0d want pix 0 wgt 10", pix_addr, wgt_addr); else n_pass++;
    wait_done(200, to);
    n_checks++; if (to !== 1'b0) $display("FAIL bp_timeout: got %0b want 0", to); else n_pass++;
    n_checks++; if (qget(q_rv, 0) !== t + 21) $display("FAIL bp_valid_time: got %0d want %0d", qget(q_rv, 0), t + 21); else n_pass++;
    n_checks++; if (qget(q_hs_cyc, 1) !== t + 47) $display("FAIL bp_hs1_time: got %0d want %0d", qget(q_hs_cyc, 1), t + 47); else n_pass++;
    n_checks++; if (qget(q_first, 1) !== t + 29) $display("FAIL bp_first1: got %0d want %0d", qget(q_first, 1), t + 29); else n_pass++;
    for (int n = 0; n < 3; n++) begin
      n_checks++; if (qget(q_hs_data, n) !== ref_sum(n)) $display("FAIL bp_data%0d: got %0d want %0d", n, qget(q_hs_data, n), ref_sum(n)); else n_pass++;
    end
    n_checks++; if (n_unstable !== 0) $display("FAIL bp_stable: got %0d changes want 0", n_unstable); else n_pass++;
    n_checks++; if (n_beats !== 30) $display("FAIL bp_beats: got %0d want 30", n_beats); else n_pass++;
  endtask

  task automatic test_random_ready();
    int t; int k;
    for (int r = 0; r < 3; r++) begin
      load_mem(1); clear_mon(); res_ready = 1'b1;
      do_start(t);
      k = 0;
      while (q_done.size() == 0 && k < 400) begin
        step(); k++;
        res_ready = 1'($urandom_range(0, 1));
      end
      res_ready = 1'b1;
      repeat (3) step();
      n_checks++; if (q_hs_data.size() !== 3) $display("FAIL rnd%0d_count: got %0d want 3", r, q_hs_data.size()); else n_pass++;
      for (int n = 0; n < 3; n++) begin
        n_checks++; if ({qget(q_hs_idx, n), qget(q_hs_data, n)} !== {n, ref_sum(n)})
          $display("FAIL rnd%0d_result%0d: got idx %0d data %0d want idx %0d data %0d", r, n, qget(q_hs_idx, n), qget(q_hs_data, n), n, ref_sum(n)); else n_pass++;
      end
      n_checks++; if (n_unstable !== 0) $display("FAIL rnd%0d_stable: got %0d want 0", r, n_unstable); else n_pass++;
      n_checks++; if (n_beats !== 30) $display("FAIL rnd%0d_beats: got %0d want 30", r, n_beats); else n_pass++;
      n_checks++; if (q_done.size() !== 1) $display("FAIL rnd%0d_done_count: got %0d want 1", r, q_done.size()); else n_pass++;
    end
  endtask

  task automatic test_start_while_busy();
    int t;
    load_mem(0); clear_mon(); res_ready = 1'b1;
    do_start(t);
    for (int k = 0; k < 75; k++) begin
      step();
      start = (cyc == t + 5 || cyc == t + 21 || cyc == t + 42 || cyc == t + 63);
    end
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      n_checks++; if (qget(q_hs_cyc, n) !== t + 21 + 21*n) $display("FAIL swb_hs_time%0d: got %0d want %0d", n, qget(q_hs_cyc, n), t + 21 + 21*n); else n_pass++;
      n_checks++; if (qget(q_hs_data, n) !== ref_sum(n)) $display("FAIL swb_data%0d: got %0d want %0d", n, qget(q_hs_data, n), ref_sum(n)); else n_pass++;
    end
    n_checks++; if (q_done.size() !== 1) $display("FAIL swb_done_count: got %0d want 1", q_done.size()); else n_pass++;
    n_checks++; if (qget(q_done, 0) !== t + 64) $display("FAIL swb_done_time: got %0d want %0d", qget(q_done, 0), t + 64); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL swb_idle_after: got busy %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int t; bit to;
    load_mem(1); clear_mon(); res_ready = 1'b1;
    do_start(t);
    while (cyc < t + 35) step();
    rst = 1'b1;
    #1;
    n_checks++; if ({busy, done, res_valid, dp_first, dp_last, dp_pix, dp_wgt, res_data, res_idx, pix_addr, wgt_addr} !== '0)
      $display("FAIL midrst_outputs: got %0h want 0", {busy, done, res_valid, dp_first, dp_last, dp_pix, dp_wgt, res_data, res_idx, pix_addr, wgt_addr}); else n_pass++;
    n_checks++; if (q_hs_data.size() !== 1) $display("FAIL midrst_prior_results: got %0d want 1", q_hs_data.size()); else n_pass++;
    step(); step();
    rst = 1'b0;
    step();
    clear_mon();
    do_start(t);
    wait_done(100, to);
    n_checks++; if (to !== 1'b0) $display("FAIL midrst_timeout: got %0b want 0", to); else n_pass++;
    n_checks++; if (qget(q_rv, 0) !== t + 21) $display("FAIL midrst_valid_time: got %0d want %0d", qget(q_rv, 0), t + 21); else n_pass++;
    n_checks++; if (qget(q_hs_idx, 0) !== 0) $display("FAIL midrst_first_idx: got %0d want 0", qget(q_hs_idx, 0)); else n_pass++;
    for (int n = 0; n < 3; n++) begin
      n_checks++; if (qget(q_hs_data, n) !== ref_sum(n)) $display("FAIL midrst_data%0d: got %0d want %0d", n, qget(q_hs_data, n), ref_sum(n)); else n_pass++;
    end
    n_checks++; if (qget(q_done, 0) !== t + 64) $display("FAIL midrst_done_time: got %0d want %0d", qget(q_done, 0), t + 64); else n_pass++;
  endtask

  task automatic test_parallel2();
    int t; int k; int rel;
    load_mem(1); clear_mon(); res_ready = 1'b1;
    t = cyc;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    k = 0;
    while (q2_done.size() == 0 && k < 100) begin
      rel = cyc - t - 1;
      if (rel >= 0 && rel < 48 && (rel % 16) < 5) begin
        n_checks++; if ({pix_addr2, wgt_addr2} !== {3'(rel % 16), 4'((rel / 16) * 5 + rel % 16)})
          $display("FAIL p2_addr_c%0d: got pix %0d wgt %0d want pix %0d wgt %0d", rel, pix_addr2, wgt_addr2, rel % 16, (rel / 16) * 5 + rel % 16); else n_pass++;
      end
      step(); k++;
    end
    n_checks++; if (q2_done.size() !== 1) $display("FAIL p2_done: got %0d want 1", q2_done.size()); else n_pass++;
    n_checks++; if (qget(q2_rv, 0) !== t + 16) $display("FAIL p2_valid_time: got %0d want %0d", qget(q2_rv, 0), t + 16); else n_pass++;
    for (int n = 0; n < 3; n++) begin
      n_checks++; if ({qget(q2_hs_idx, n), qget(q2_hs_data, n)} !== {n, ref_sum(n)})
        $display("FAIL p2_result%0d: got idx %0d data %0d want idx %0d data %0d", n, qget(q2_hs_idx, n), qget(q2_hs_data, n), n, ref_sum(n)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_run();
    test_backpressure();
    test_random_ready();
    test_start_while_busy();
    test_reset_mid_run();
    test_parallel2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t want completion", $time);
    $fatal(1);
  end

endmodule
